// File: rtl/disp_trace_fifo_if.sv
// Read-side handshake of the display trace buffer: show-ahead head entry
// offered with RdValid, consumed when the host raises RdReady.
interface disp_trace_fifo_if #(
  parameter int unsigned ENTRY_W = 49
) ();
  logic               RdValid;
  logic               RdReady;
  logic [ENTRY_W-1:0] RdData;

  modport master (output RdValid, output RdData, input RdReady);
  modport slave  (input RdValid, input RdData, output RdReady);
endinterface

// File: rtl/disp_trace_fifo.sv
// Display-window trace buffer: while the selected DispVal bit is high, valid
// link words are captured with a free-running timestamp into a ring buffer;
// the falling edge of the window appends a marker carrying the word count.
module disp_trace_fifo #(
  parameter int unsigned DISP_BITS = 8,
  parameter int unsigned SEL_BIT   = 0,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TS_W      = 16
) (
  input  logic                         Clk,
  input  logic                         notReset,
  input  logic [DISP_BITS-1:0]         DispVal,
  input  logic [DATA_W-1:0]            LinkData,
  input  logic                         LinkValid,
  disp_trace_fifo_if.master            Rd,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  input  logic                         OvfClr,
  output logic                         Overflow,
  output logic                         Active
);

  localparam int unsigned ENTRY_W = 1 + TS_W + DATA_W;
  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned WIN_W   = (DATA_W < 16) ? DATA_W : 16;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state, stateNext;
  logic [TS_W-1:0]    ts;
  logic [WIN_W-1:0]   winCnt, winCntNext, winInc;
  logic [PTR_W-1:0]   wrPtr, rdPtr;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] wrEntry;
  logic               wrReq, doWrite, drop, pop, full, en;

  // X/Z on the gate bit is treated as a closed window.
  assign en      = (DispVal[SEL_BIT] === 1'b1);
  assign winInc  = (winCnt == '1) ? winCnt : winCnt + WIN_W'(1);
  assign full    = (Count == CNT_W'(DEPTH));
  assign pop     = (Count != '0) && Rd.RdReady;
  // A pop on the same edge frees the slot, so a full buffer still accepts.
  assign doWrite = wrReq && (!full || pop);
  assign drop    = wrReq && full && !pop;

  assign Rd.RdValid = (Count != '0);
  assign Rd.RdData  = mem[rdPtr];
  assign Active     = (state == ACTIVE);

  // Window FSM: decides what (if anything) is written this cycle.
  always_comb begin
    stateNext  = state;
    wrReq      = 1'b0;
    wrEntry    = '0;
    winCntNext = winCnt;
    unique case (state)
      IDLE: begin
        if (en) begin
          stateNext = ACTIVE;
          if (LinkValid) begin
            wrReq      = 1'b1;
            wrEntry    = {1'b0, ts, LinkData};
            winCntNext = winInc;
          end
        end
      end
      ACTIVE: begin
        if (en) begin
          if (LinkValid) begin
            wrReq      = 1'b1;
            wrEntry    = {1'b0, ts, LinkData};
            winCntNext = winInc;
          end
        end else begin
          stateNext  = IDLE;
          wrReq      = 1'b1;
          wrEntry    = {1'b1, ts, DATA_W'(winCnt)};
          winCntNext = '0;
        end
      end
    endcase
  end

  // Control state, timestamp, pointers, occupancy and sticky overflow.
  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      state    <= IDLE;
      ts       <= '0;
      winCnt   <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      Count    <= '0;
      Overflow <= 1'b0;
    end else begin
      state  <= stateNext;
      ts     <= ts + TS_W'(1);
      winCnt <= winCntNext;
      if (doWrite) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)     rdPtr <= rdPtr + PTR_W'(1);
      if (doWrite && !pop)      Count <= Count + CNT_W'(1);
      else if (!doWrite && pop) Count <= Count - CNT_W'(1);
      if (drop)        Overflow <= 1'b1;
      else if (OvfClr) Overflow <= 1'b0;
    end
  end

  // Entry storage; contents survive reset and are only meaningful under RdValid.
  always_ff @(posedge Clk) begin
    if (doWrite) mem[wrPtr] <= wrEntry;
  end

endmodule

// File: tb/tb_disp_trace_fifo.sv
// Bench for disp_trace_fifo: two instances (16-bit and 4-bit timestamps) share
// stimulus; a reference queue predicts every buffered entry.
module tb_disp_trace_fifo;

  logic        clk;
  logic        notReset;
  logic [7:0]  dispVal;
  logic [31:0] linkData;
  logic        linkValid;
  logic        rdReady;
  logic        ovfClr;
  logic [4:0]  countA, countB;
  logic        ovfA, ovfB, actA, actB;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [48:0] expQ[$];
  logic        mAct;
  logic [15:0] mWin;
  logic [15:0] mTs;
  logic        mOvf;

  disp_trace_fifo_if #(.ENTRY_W(49)) rdA ();
  disp_trace_fifo_if #(.ENTRY_W(37)) rdB ();
  assign rdA.RdReady = rdReady;
  assign rdB.RdReady = rdReady;

  disp_trace_fifo #(.DISP_BITS(8), .SEL_BIT(0), .DATA_W(32), .DEPTH(16), .TS_W(16)) dutA (
    .Clk(clk), .notReset(notReset), .DispVal(dispVal), .LinkData(linkData),
    .LinkValid(linkValid), .Rd(rdA.master), .Count(countA), .OvfClr(ovfClr),
    .Overflow(ovfA), .Active(actA));

  disp_trace_fifo #(.DISP_BITS(8), .SEL_BIT(0), .DATA_W(32), .DEPTH(16), .TS_W(4)) dutB (
    .Clk(clk), .notReset(notReset), .DispVal(dispVal), .LinkData(linkData),
    .LinkValid(linkValid), .Rd(rdB.master), .Count(countB), .OvfClr(ovfClr),
    .Overflow(ovfB), .Active(actB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    logic [48:0] h;
    check("countA", 64'(countA), 64'(expQ.size()));
    check("countB", 64'(countB), 64'(expQ.size()));
    check("validA", 64'(rdA.RdValid), 64'(expQ.size() != 0));
    check("validB", 64'(rdB.RdValid), 64'(expQ.size() != 0));
    check("ovfA", 64'(ovfA), 64'(mOvf));
    check("ovfB", 64'(ovfB), 64'(mOvf));
    check("actA", 64'(actA), 64'(mAct));
    check("actB", 64'(actB), 64'(mAct));
    if (expQ.size() != 0) begin
      h = expQ[0];
      check("dataA", 64'(rdA.RdData), 64'(h));
      check("dataB", 64'(rdB.RdData), 64'({h[48], h[35:32], h[31:0]}));
    end
  endtask

  task automatic setDisp(input logic en);
    dispVal = {7'($urandom()), en};
  endtask

  // One clock: advance the model with the inputs seen at the edge, then check.
  task automatic tick();
    logic        en, pop, wr, ovfSet;
    logic [48:0] ent;
    @(posedge clk);
    en  = (dispVal[0] === 1'b1);
    pop = (expQ.size() != 0) && rdReady;
    wr  = 1'b0;
    ent = '0;
    if (en) begin
      mAct = 1'b1;
      if (linkValid) begin
        wr  = 1'b1;
        ent = {1'b0, mTs, linkData};
        if (mWin != 16'hFFFF) mWin++;
      end
    end else if (mAct) begin
      wr   = 1'b1;
      ent  = {1'b1, mTs, 16'h0000, mWin};
      mWin = '0;
      mAct = 1'b0;
    end
    ovfSet = wr && (expQ.size() == 16) && !pop;
    if (pop) void'(expQ.pop_front());
    if (wr && !ovfSet) expQ.push_back(ent);
    if (ovfSet) mOvf = 1'b1;
    else if (ovfClr) mOvf = 1'b0;
    mTs++;
    #1;
    checkAll();
  endtask

  task automatic doReset();
    #2;
    notReset = 1'b0;
    #1;
    expQ.delete();
    mAct = 1'b0; mWin = '0; mTs = '0; mOvf = 1'b0;
    check("rst_countA", 64'(countA), 64'd0);
    check("rst_validA", 64'(rdA.RdValid), 64'd0);
    check("rst_actA", 64'(actA), 64'd0);
    check("rst_ovfA", 64'(ovfA), 64'd0);
    check("rst_countB", 64'(countB), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    notReset = 1'b1;
  endtask

  initial begin
    notReset = 1'b0; dispVal = '0; linkData = '0; linkValid = 1'b0;
    rdReady = 1'b0; ovfClr = 1'b0;
    doReset();

    // Closed window: nothing captured despite valid words and other DispVal bits
    linkValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      setDisp(1'b0); linkData = 32'($urandom()); tick();
    end
    check("t1_count", 64'(countA), 64'd0);

    // Four-word window followed by its marker
    for (int i = 0; i < 4; i++) begin
      setDisp(1'b1); linkData = 32'h10 + 32'(i); tick();
    end
    setDisp(1'b0); linkData = 32'hDEAD_BEEF; tick();
    check("t2_count", 64'(countA), 64'd5);
    check("t2_head", 64'(rdA.RdData[31:0]), 64'h10);
    linkValid = 1'b0; rdReady = 1'b1;
    repeat (6) tick();

    // Overfill: oldest 16 kept, overflow sticky until cleared
    rdReady = 1'b0; linkValid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      setDisp(1'b1); linkData = 32'h100 + 32'(i); tick();
    end
    check("t3_count", 64'(countA), 64'd16);
    check("t3_ovf", 64'(ovfA), 64'd1);
    linkValid = 1'b0; ovfClr = 1'b1; tick();
    ovfClr = 1'b0;
    check("t3_clr", 64'(ovfA), 64'd0);

    // Full buffer with simultaneous push and pop
    rdReady = 1'b1; linkValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      setDisp(1'b1); linkData = 32'h200 + 32'(i); tick();
    end
    check("t4_count", 64'(countA), 64'd16);
    check("t4_ovf", 64'(ovfA), 64'd0);
    setDisp(1'b0); linkValid = 1'b0; tick();
    repeat (17) tick();
    check("t4_drained", 64'(countA), 64'd0);

    // Reset in the middle of a window
    rdReady = 1'b0; linkValid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      setDisp(1'b1); linkData = 32'h300 + 32'(i); tick();
    end
    check("t5_count", 64'(countA), 64'd7);
    doReset();
    setDisp(1'b0); linkValid = 1'b0;
    repeat (3) tick();
    check("t5_nomark", 64'(countA), 64'd0);

    // Long window with draining: 4-bit timestamp wraps
    rdReady = 1'b1; linkValid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      setDisp(1'b1); linkData = 32'($urandom()); tick();
    end
    setDisp(1'b0); linkValid = 1'b0; tick();
    repeat (3) tick();

    // Mixed random traffic
    for (int i = 0; i < 60; i++) begin
      setDisp((i % 16) < 11);
      linkValid = 1'($urandom());
      linkData = 32'($urandom());
      rdReady = ($urandom_range(0, 3) != 0);
      ovfClr = ($urandom_range(0, 7) == 0);
      tick();
    end
    ovfClr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
